bidir_shift_serializer: RTL and testbench
=========================================

# bidir_shift_serializer

Parallel-in, serial-out transmitter that produces the serial stream consumed by our bidirectional shift register. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock. The shift direction is selectable per word: LSB-first for right-shift consumers, MSB-first for left-shift consumers. It sits upstream of the shift-register receivers and supports back-to-back words with no idle gap.

## Interface
- WIDTH, 4, word length in bits; must be ≥ 2
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- din  in  WIDTH  parallel word to transmit
- din_valid  in  1  din is presented
- din_ready  out  1  block can accept din this cycle (combinational)
- mode  in  1  direction, sampled only at accept: 1 = LSB first (right shift), 0 = MSB first (left shift)
- sout  out  1  serial data bit (registered)
- sout_valid  out  1  sout carries a valid bit (registered)
- last  out  1  sout is the final bit of the current word (registered)
- busy  out  1  a word is in flight (state == SHIFT)

## Operation
- Internal state:
  - FSM states IDLE and SHIFT.
  - shreg[WIDTH-1:0] holds the bits not yet sent.
  - cnt is a bit counter, width $clog2(WIDTH+1), counting bits already driven onto sout.
  - mode_q is the direction latched at accept.
- din_ready = !rst && (state == IDLE || (state == SHIFT && cnt == WIDTH)).
- accept = din_valid && din_ready.
- On accept (from IDLE or from SHIFT during the last bit):
  - mode_q <= mode.
  - sout <= mode ? din[0] : din[WIDTH-1].
  - shreg <= mode ? din >> 1 : din << 1, with zero fill.
  - cnt <= 1; sout_valid <= 1; last <= 0; state <= SHIFT.
- In SHIFT with cnt < WIDTH:
  - sout <= mode_q ? shreg[0] : shreg[WIDTH-1].
  - shreg shifts one place in the mode_q direction with zero fill.
  - cnt <= cnt + 1; last <= (cnt == WIDTH-1).
- In SHIFT with cnt == WIDTH and no accept:
  - state <= IDLE; sout_valid <= 0; last <= 0; sout <= 0; cnt <= 0.
- Changes on mode or din while busy have no effect. Only the values sampled at accept matter.
- din_valid without din_ready is ignored. There is no buffering, so the upstream holds din_valid until it sees din_ready.
- Reset:
  - Takes effect at the rising edge where rst = 1.
  - Aborts any word mid-transmission.
  - After reset: state IDLE; sout = 0, sout_valid = 0, last = 0, busy = 0; shreg = 0, cnt = 0.
  - din_ready = 0 while rst is high, and 1 from the first cycle after rst falls.

## Timing
- Accept at edge k: the first bit is on sout after edge k. Bit i (i = 0..WIDTH-1) is valid from edge k+i to edge k+i+1.
- sout_valid is high for exactly WIDTH consecutive cycles per word. last is high only during bit WIDTH-1.
- Back-to-back: din_ready rises during the last bit cycle. An accept there makes the next word's bit 0 follow at the next edge with no gap; sout_valid stays high.
- Without a back-to-back accept, sout_valid falls one cycle after last. The earliest next accept is in that cycle, because din_ready is already 1 there.
- Latency from accept to first bit: 1 edge. Throughput: 1 bit per clock, WIDTH cycles per word.

## Test plan
- Reset values: hold rst for 2 cycles with din_valid = 1 -> sout = sout_valid = last = busy = 0 and din_ready = 0 throughout; no word is accepted.
- LSB-first: WIDTH = 4, din = 4'b1011, mode = 1, one-cycle din_valid -> sout = 1,1,0,1 on 4 consecutive cycles; last on the 4th; sout_valid falls afterwards.
- MSB-first: din = 4'b1011, mode = 0 -> sout = 1,0,1,1; last on the 4th bit.
- Back-to-back: din_valid held high with 4'b1011 (mode = 1), then 4'b0110 (mode = 0) presented during the last bit -> 8 contiguous valid bits 1,1,0,1,0,1,1,0; sout_valid never drops; last on bits 4 and 8.
- Mid-word stability: after accepting 4'b1011 with mode = 1, toggle mode and change din every cycle -> output is still 1,1,0,1; din_ready stays 0 until the 4th bit.
- Reset mid-word: rst = 1 for one cycle during bit 2 -> all outputs are 0 at the next edge and busy = 0; a new word of 4'b0001 with mode = 0 is then sent cleanly as 0,0,0,1.

Source files
------------

// File: rtl/bidir_shift_serializer.sv
// Parallel-in, serial-out transmitter with per-word direction select.
// Feeds the bidirectional shift-register receivers, back-to-back capable.
module bidir_shift_serializer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             mode,
   output logic             sout,
   output logic             sout_valid,
   output logic             last,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic             sout_q, sout_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic             at_end;
   logic             accept;

   // cnt == WIDTH means the final bit is on sout right now
   assign at_end    = (cnt_q == CW'(WIDTH));
   assign din_ready = !rst && (state_q == IDLE ||
                               (state_q == SHIFT && at_end));
   assign accept    = din_valid && din_ready;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      sout_d  = sout_q;
      valid_d = valid_q;
      last_d  = last_q;
      if (accept) begin
         mode_d  = mode;
         sout_d  = mode ? din[0] : din[WIDTH-1];
         shreg_d = mode ? (din >> 1) : (din << 1);
         cnt_d   = CW'(1);
         valid_d = 1'b1;
         last_d  = 1'b0;
         state_d = SHIFT;
      end else if (state_q == SHIFT) begin
         if (!at_end) begin
            sout_d  = mode_q ? shreg_q[0] : shreg_q[WIDTH-1];
            shreg_d = mode_q ? (shreg_q >> 1) : (shreg_q << 1);
            cnt_d   = cnt_q + CW'(1);
            last_d  = (cnt_q == CW'(WIDTH - 1));
         end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            sout_d  = 1'b0;
            cnt_d   = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         sout_q  <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         sout_q  <= sout_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign sout       = sout_q;
   assign sout_valid = valid_q;
   assign last       = last_q;
   assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_bidir_shift_serializer.sv
// Directed bench for bidir_shift_serializer (WIDTH = 4).
// Inputs driven and outputs sampled on the falling edge.
module tb_bidir_shift_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] din;
   logic       din_valid;
   logic       din_ready;
   logic       mode;
   logic       sout;
   logic       sout_valid;
   logic       last;
   logic       busy;

   int checks = 0;
   int errors = 0;

   bidir_shift_serializer #(.WIDTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .mode       (mode),
      .sout       (sout),
      .sout_valid (sout_valid),
      .last       (last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_outputs(input string tag, input logic rdy);
      check({tag, ".sout"}, 8'(sout), 8'd0);
      check({tag, ".valid"}, 8'(sout_valid), 8'd0);
      check({tag, ".last"}, 8'(last), 8'd0);
      check({tag, ".busy"}, 8'(busy), 8'd0);
      check({tag, ".ready"}, 8'(din_ready), 8'(rdy));
   endtask

   // Present a word at this falling edge; it is accepted at the next rise.
   task automatic offer(input logic [3:0] w, input logic m);
      din       = w;
      mode      = m;
      din_valid = 1'b1;
      check("offer.ready", 8'(din_ready), 8'd1);
      @(negedge clk);
   endtask

   // Check four emitted bits; bits[i] is the i-th bit expected on sout.
   // scr: scramble din/mode each cycle. nxt: offer nw/nm during last bit.
   task automatic expect_bits(input string tag, input logic [3:0] bits,
                              input bit scr, input bit nxt,
                              input logic [3:0] nw, input logic nm);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s.b%0d", tag, i), 8'(sout), 8'(bits[i]));
         check($sformatf("%s.v%0d", tag, i), 8'(sout_valid), 8'd1);
         check($sformatf("%s.l%0d", tag, i), 8'(last), 8'(i == 3));
         check($sformatf("%s.y%0d", tag, i), 8'(busy), 8'd1);
         check($sformatf("%s.r%0d", tag, i), 8'(din_ready), 8'(i == 3));
         if (i == 3 && nxt) begin
            din       = nw;
            mode      = nm;
            din_valid = 1'b1;
         end else if (scr && i < 3) begin
            din       = ~din;
            mode      = ~mode;
            din_valid = 1'b1;
         end else begin
            din_valid = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst       = 1'b1;
      din       = 4'b1011;
      mode      = 1'b1;
      din_valid = 1'b1;

      @(negedge clk);
      idle_outputs("rst0", 1'b0);
      @(negedge clk);
      idle_outputs("rst1", 1'b0);
      rst       = 1'b0;
      din_valid = 1'b0;
      #1;
      check("rst.ready_after", 8'(din_ready), 8'd1);
      @(negedge clk);
      idle_outputs("post_rst", 1'b1);

      // LSB first: 1011 -> 1,1,0,1
      offer(4'b1011, 1'b1);
      expect_bits("lsb", 4'b1011, 1'b0, 1'b0, 4'h0, 1'b0);
      idle_outputs("lsb.end", 1'b1);

      // MSB first: 1011 -> 1,0,1,1
      offer(4'b1011, 1'b0);
      expect_bits("msb", 4'b1101, 1'b0, 1'b0, 4'h0, 1'b0);
      idle_outputs("msb.end", 1'b1);

      // Back-to-back: 1011 LSB then 0110 MSB -> 1,1,0,1,0,1,1,0
      offer(4'b1011, 1'b1);
      expect_bits("b2b_a", 4'b1011, 1'b0, 1'b1, 4'b0110, 1'b0);
      expect_bits("b2b_b", 4'b0110, 1'b0, 1'b0, 4'h0, 1'b0);
      idle_outputs("b2b.end", 1'b1);

      // Inputs churn while busy; output unaffected
      offer(4'b1011, 1'b1);
      expect_bits("stab", 4'b1011, 1'b1, 1'b0, 4'h0, 1'b0);
      idle_outputs("stab.end", 1'b1);

      // Reset during bit 2, then clean word 0001 MSB first
      offer(4'b1011, 1'b1);
      din_valid = 1'b0;
      check("mid.b0", 8'(sout), 8'd1);
      @(negedge clk);
      check("mid.b1", 8'(sout), 8'd1);
      @(negedge clk);
      check("mid.v2", 8'(sout_valid), 8'd1);
      check("mid.y2", 8'(busy), 8'd1);
      rst = 1'b1;
      @(negedge clk);
      idle_outputs("mid.rst", 1'b0);
      rst = 1'b0;
      #1;
      check("mid.ready", 8'(din_ready), 8'd1);
      @(negedge clk);
      idle_outputs("mid.idle", 1'b1);
      offer(4'b0001, 1'b0);
      expect_bits("mid.new", 4'b1000, 1'b0, 1'b0, 4'h0, 1'b0);
      idle_outputs("mid.end", 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
